// File: rtl/mdu_pkg.sv
// MDU shared types: op codes, FSM states, op-class helpers.
// MDU_MADD_EN widens the op to 4 bits and adds MADD/MADDU/MSUB/MSUBU.
package mdu_pkg;

`ifdef MDU_MADD_EN
  localparam int OPW = 4;
`else
  localparam int OPW = 3;
`endif

  typedef logic [OPW-1:0] mdu_op_t;

  localparam mdu_op_t MDU_MULT  = mdu_op_t'(0);
  localparam mdu_op_t MDU_MULTU = mdu_op_t'(1);
  localparam mdu_op_t MDU_DIV   = mdu_op_t'(2);
  localparam mdu_op_t MDU_DIVU  = mdu_op_t'(3);
  localparam mdu_op_t MDU_MTHI  = mdu_op_t'(4);
  localparam mdu_op_t MDU_MTLO  = mdu_op_t'(5);
  localparam mdu_op_t MDU_MADD  = mdu_op_t'(6);
  localparam mdu_op_t MDU_MADDU = mdu_op_t'(7);
`ifdef MDU_MADD_EN
  localparam mdu_op_t MDU_MSUB  = mdu_op_t'(8);
  localparam mdu_op_t MDU_MSUBU = mdu_op_t'(9);
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic is_mul(mdu_op_t op);
`ifdef MDU_MADD_EN
    return op == MDU_MULT || op == MDU_MULTU ||
           op == MDU_MADD || op == MDU_MADDU ||
           op == MDU_MSUB || op == MDU_MSUBU;
`else
    return op == MDU_MULT || op == MDU_MULTU;
`endif
  endfunction

  function automatic logic is_div(mdu_op_t op);
    return op == MDU_DIV || op == MDU_DIVU;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// MDU operand/control/result bundle between EX stage and the MDU.
// master drives the request, slave returns busy and HI/LO.
interface mdu_if;
  import mdu_pkg::*;

  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        start;
  mdu_op_t     mdu_op;
  logic        rd_hi;
  logic        busy;
  logic [31:0] mdu_out;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output dataA, dataB, start, mdu_op, rd_hi,
    input  busy, mdu_out, hi, lo
  );

  modport slave (
    input  dataA, dataB, start, mdu_op, rd_hi,
    output busy, mdu_out, hi, lo
  );
endinterface

// File: rtl/mdu_arith.sv
// Combinational 64-bit {hi,lo} result for one MDU op.
// MDU_MADD_EN adds the accumulate/subtract forms.
module mdu_arith
  import mdu_pkg::*;
(
  input  mdu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);

  logic [63:0] acc;
  logic [63:0] smul;
  logic [63:0] umul;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [31:0] sdv;
  logic [31:0] udv;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] uq;
  logic [31:0] ur;
  logic        bz;

  assign acc  = {hi, lo};
  assign smul = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign umul = {32'd0, a} * {32'd0, b};

  // Signed divide on magnitudes; 0x80000000/-1 folds back to itself.
  assign ma  = a[31] ? -a : a;
  assign mb  = b[31] ? -b : b;
  assign bz  = (b == 32'd0);
  assign sdv = bz ? 32'd1 : mb;
  assign udv = bz ? 32'd1 : b;
  assign sq  = ma / sdv;
  assign sr  = ma % sdv;
  assign uq  = a / udv;
  assign ur  = a % udv;

  // Select result; divide by zero keeps current hi/lo.
  always_comb begin
    res = acc;
    unique case (1'b1)
      op == MDU_MULT:  res = smul;
      op == MDU_MULTU: res = umul;
      op == MDU_DIV: begin
        if (!bz)
          res = {a[31] ? -sr : sr,
                 (a[31] ^ b[31]) ? -sq : sq};
      end
      op == MDU_DIVU: begin
        if (!bz)
          res = {ur, uq};
      end
`ifdef MDU_MADD_EN
      op == MDU_MADD:  res = acc + smul;
      op == MDU_MADDU: res = acc + umul;
      op == MDU_MSUB:  res = acc - smul;
      op == MDU_MSUBU: res = acc - umul;
`endif
      default:         res = acc;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// MDU_MADD_EN enables multiply-accumulate ops.
module mdu
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic clk,
  input logic reset,
  mdu_if.slave bus
);

  localparam int CMAX =
    (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(CMAX + 1);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [63:0]   pend_q;
  logic [63:0]   res;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic          idle;
  logic          acc_mul;
  logic          acc_div;
  logic          wr_hi;
  logic          wr_lo;
  logic          commit;

  mdu_arith u_arith (
    .op  (bus.mdu_op),
    .a   (bus.dataA),
    .b   (bus.dataB),
    .hi  (hi_q),
    .lo  (lo_q),
    .res (res)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: accept in IDLE, leave RUN on last count.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (acc_mul || acc_div) state_d = ST_RUN;
      ST_RUN:  if (commit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Decode strobes and busy from state and request.
  always_comb begin
    idle    = (state_q == ST_IDLE);
    acc_mul = idle && bus.start && is_mul(bus.mdu_op);
    acc_div = idle && bus.start && is_div(bus.mdu_op);
    wr_hi   = idle && bus.start && bus.mdu_op == MDU_MTHI;
    wr_lo   = idle && bus.start && bus.mdu_op == MDU_MTLO;
    commit  = !idle && cnt_q == CW'(1);
    bus.busy = !idle;
  end

  // Counter, pending result and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      pend_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      if (acc_mul) begin
        cnt_q  <= CW'(MUL_CYCLES);
        pend_q <= res;
      end else if (acc_div) begin
        cnt_q  <= CW'(DIV_CYCLES);
        pend_q <= res;
      end else if (!idle) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (commit) begin
        hi_q <= pend_q[63:32];
        lo_q <= pend_q[31:0];
      end
      if (wr_hi) hi_q <= bus.dataA;
      if (wr_lo) lo_q <= bus.dataA;
    end
  end

  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.mdu_out = bus.rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for the MDU.
// Define MDU_MADD_EN to check the accumulate op.
module tb_mdu;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   nchk = 0;
  int   nerr = 0;
  int   n;

  mdu_if bus ();

  mdu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic issue(input mdu_op_t op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mdu_op = op;
    bus.dataA  = a;
    bus.dataB  = b;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic run(output int cyc);
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic op_chk(input string tag,
                        input mdu_op_t op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int lat,
                        input logic [31:0] ehi,
                        input logic [31:0] elo);
    int c;
    issue(op, a, b);
    run(c);
    chk({tag, ".lat"}, 32'(c), 32'(lat));
    chk({tag, ".hi"}, bus.hi, ehi);
    chk({tag, ".lo"}, bus.lo, elo);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.mdu_op = MDU_MULT;
    bus.dataA  = '0;
    bus.dataB  = '0;
    bus.rd_hi  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.hi", bus.hi, 32'd0);
    chk("rst.lo", bus.lo, 32'd0);
    chk("rst.out", bus.mdu_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    op_chk("mult", MDU_MULT, 32'hFFFFFFFE, 32'd3,
           5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    op_chk("multu", MDU_MULTU, 32'hFFFFFFFE, 32'd3,
           5, 32'd2, 32'hFFFFFFFA);
    op_chk("multnn", MDU_MULT, 32'hFFFFFFFE,
           32'hFFFFFFFD, 5, 32'd0, 32'd6);
    op_chk("div", MDU_DIV, 32'hFFFFFFF9, 32'd2,
           10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    op_chk("divu", MDU_DIVU, 32'd7, 32'd2,
           10, 32'd1, 32'd3);
    op_chk("divpn", MDU_DIV, 32'd7, 32'hFFFFFFFE,
           10, 32'd1, 32'hFFFFFFFD);

    issue(MDU_MULT, 32'd2, 32'd3);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mdu_op = MDU_MTLO;
    bus.dataA  = 32'h99;
    bus.rd_hi  = 1'b0;
    #1;
    chk("hold.lo", bus.mdu_out, 32'hFFFFFFFD);
    bus.rd_hi = 1'b1;
    #1;
    chk("hold.hi", bus.mdu_out, 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.rd_hi = 1'b0;
    run(n);
    chk("ign.lat", 32'(n), 32'd3);
    chk("ign.lo", bus.lo, 32'd6);
    chk("ign.hi", bus.hi, 32'd0);

    issue(MDU_MTHI, 32'h11, 32'd0);
    chk("mthi.busy", 32'(bus.busy), 32'd0);
    issue(MDU_MTLO, 32'h22, 32'd0);
    chk("mtlo.hi", bus.hi, 32'h11);
    chk("mtlo.lo", bus.lo, 32'h22);
    op_chk("div0", MDU_DIV, 32'd5, 32'd0,
           10, 32'h11, 32'h22);
    op_chk("divov", MDU_DIV, 32'h80000000,
           32'hFFFFFFFF, 10, 32'd0, 32'h80000000);

    issue(MDU_MTHI, 32'h55, 32'd0);
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst.busy", 32'(bus.busy), 32'd0);
    chk("arst.hi", bus.hi, 32'd0);
    chk("arst.lo", bus.lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("arst.idle", 32'(bus.busy), 32'd0);
    chk("arst.hi2", bus.hi, 32'd0);
    chk("arst.lo2", bus.lo, 32'd0);
    op_chk("multu44", MDU_MULTU, 32'd4, 32'd4,
           5, 32'd0, 32'd16);

    issue(MDU_MTHI, 32'd0, 32'd0);
    issue(MDU_MTLO, 32'hFFFFFFFF, 32'd0);
`ifdef MDU_MADD_EN
    op_chk("maddu", MDU_MADDU, 32'd1, 32'd1,
           5, 32'd1, 32'd0);
`else
    op_chk("maddu", MDU_MADDU, 32'd1, 32'd1,
           0, 32'd0, 32'hFFFFFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
